// File: rtl/mem_access_unit.sv
// Load/store initiator between the CPU datapath and data_memory: one request at a
// time, strobes held for a settle window, one-cycle response. Option: MAU_READBACK_EN.
module mem_access_unit #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy,
  output logic              mem_enable,
  output logic              mem_write,
  output logic [ADDR_W-1:0] read_addr,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data
);

  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             wr_q;
  logic             accept_c;
  logic             ready_nxt, busy_nxt, en_nxt, we_nxt, resp_nxt;

  assign accept_c = req_valid && req_ready && (state == S_IDLE);

  // Next state and next registered output values
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      S_IDLE: begin
        if (accept_c) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        wait_cnt_nxt = CNT_W'(WAIT_CYCLES);
        if (WAIT_CYCLES != 0) state_nxt = S_WAIT;
        else                  state_nxt = S_RESP;
      end
      S_WAIT: begin
        wait_cnt_nxt = wait_cnt - CNT_W'(1);
        if (wait_cnt == CNT_W'(1)) state_nxt = S_RESP;
      end
      S_RESP: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    ready_nxt = (state_nxt == S_IDLE);
    busy_nxt  = (state_nxt != S_IDLE);
    en_nxt    = (state_nxt == S_ISSUE) || (state_nxt == S_WAIT);
    // Write strobe only in ISSUE, which is entered solely from an accept
    we_nxt    = accept_c && req_write;
    resp_nxt  = (state_nxt == S_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      req_ready  <= 1'b0;
      busy       <= 1'b0;
      mem_enable <= 1'b0;
      mem_write  <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_cnt_nxt;
      req_ready  <= ready_nxt;
      busy       <= busy_nxt;
      mem_enable <= en_nxt;
      mem_write  <= we_nxt;
      resp_valid <= resp_nxt;
    end
  end

  // Request latch: drives the memory address/data until the next accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_addr  <= '0;
      write_addr <= '0;
      write_data <= '0;
      wr_q       <= 1'b0;
    end else if (accept_c) begin
      read_addr  <= req_addr;
      write_addr <= req_addr;
      write_data <= req_wdata;
      wr_q       <= req_write;
    end
  end

`ifdef MAU_READBACK_EN
  // Capture on the edge entering RESP; stores compare the readback against the store data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (resp_nxt) begin
      resp_rdata <= read_data;
      resp_err   <= wr_q && (read_data != write_data);
    end
  end
`else
  // Capture on the edge entering RESP; stores echo their own data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_rdata <= '0;
    end else if (resp_nxt) begin
      resp_rdata <= wr_q ? write_data : read_data;
    end
  end

  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (WAIT_CYCLES 0 and 1), each with a
// write-first memory model; table vectors plus hand sequences, scoreboard queue.
module tb_mem_access_unit;

  typedef struct {
    int         sel;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic       exp_err;
  } vec_t;

  typedef struct {
    int         sel;
    logic [7:0] rdata;
    logic       err;
    int         acc;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic mem_clr;
  always #5 clk = ~clk;

  logic [1:0]      req_valid, req_ready, req_write;
  logic [1:0][7:0] req_addr, req_wdata;
  logic [1:0]      resp_valid, resp_err, busy, mem_enable, mem_write;
  logic [1:0][7:0] resp_rdata, read_addr, write_addr, write_data, read_data;
  logic [1:0]      force_zero;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [7:0]   mem [256];
    logic [255:0] written;

    mem_access_unit #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(g)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_write  (req_write[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .resp_valid (resp_valid[g]),
      .resp_rdata (resp_rdata[g]),
      .resp_err   (resp_err[g]),
      .busy       (busy[g]),
      .mem_enable (mem_enable[g]),
      .mem_write  (mem_write[g]),
      .read_addr  (read_addr[g]),
      .write_addr (write_addr[g]),
      .write_data (write_data[g]),
      .read_data  (read_data[g])
    );

    always @(posedge clk) begin
      if (mem_clr) begin
        written <= '0;
      end else if (mem_enable[g] && mem_write[g]) begin
        mem[write_addr[g]]     <= write_data[g];
        written[write_addr[g]] <= 1'b1;
      end
    end

    // Unwritten locations hold addr ^ 0x19 (so 0x10 reads 0x09)
    assign read_data[g] = force_zero[g] ? 8'h00 :
                          (mem_enable[g] && mem_write[g] && read_addr[g] == write_addr[g]) ? write_data[g] :
                          written[read_addr[g]] ? mem[read_addr[g]] : (read_addr[g] ^ 8'h19);
  end

  int         en_cnt [2] = '{0, 0};
  int         we_cnt [2] = '{0, 0};
  int         obs_n  [2] = '{0, 0};
  logic [7:0] obs_rdata [2][64];
  logic       obs_err   [2][64];
  int         obs_cyc   [2][64];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_enable[i]) en_cnt[i] <= en_cnt[i] + 1;
      if (mem_write[i])  we_cnt[i] <= we_cnt[i] + 1;
      if (resp_valid[i]) begin
        obs_rdata[i][obs_n[i] % 64] <= resp_rdata[i];
        obs_err[i][obs_n[i] % 64]   <= resp_err[i];
        obs_cyc[i][obs_n[i] % 64]   <= cyc;
        obs_n[i]                    <= obs_n[i] + 1;
      end
    end
  end

  int   n_checks = 0;
  int   n_pass   = 0;
  int   rd_idx [2] = '{0, 0};
  exp_t exp_q [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic do_req(input int s, input logic w, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] er, input logic ee, input logic push, output int acc);
    int n;
    n = 0;
    req_valid[s] = 1'b1;
    req_write[s] = w;
    req_addr[s]  = a;
    req_wdata[s] = d;
    while (!req_ready[s] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 32'(req_ready[s]), 32'd1);
    if (!req_ready[s]) begin
      req_valid[s] = 1'b0;
      acc = -1;
      return;
    end
    @(negedge clk);
    acc = cyc;
    req_valid[s] = 1'b0;
    if (push) exp_q.push_back('{s, er, ee, acc, 1 + s});
  endtask

  task automatic wait_resp();
    exp_t e;
    int   n;
    int   k;
    n = 0;
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    while (obs_n[e.sel] <= rd_idx[e.sel] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("resp_seen", 32'(obs_n[e.sel] > rd_idx[e.sel]), 32'd1);
    if (obs_n[e.sel] > rd_idx[e.sel]) begin
      k = rd_idx[e.sel] % 64;
      check("resp_rdata", 32'(obs_rdata[e.sel][k]), 32'(e.rdata));
      check("resp_err", 32'(obs_err[e.sel][k]), 32'(e.err));
      check("resp_latency", 32'(obs_cyc[e.sel][k] - e.acc), 32'(e.lat));
      rd_idx[e.sel]++;
    end
  endtask

  initial begin
    vec_t       vecs [9];
    int         acc, acc2, en0, we0;
    logic [7:0] rb_rdata;
    logic       rb_err;

    vecs[0] = '{1, 1'b0, 8'h10, 8'h00, 8'h09, 1'b0};
    vecs[1] = '{0, 1'b1, 8'hFF, 8'hA5, 8'hA5, 1'b0};
    vecs[2] = '{0, 1'b0, 8'hFF, 8'h00, 8'hA5, 1'b0};
    vecs[3] = '{1, 1'b1, 8'h80, 8'h5A, 8'h5A, 1'b0};
    vecs[4] = '{1, 1'b0, 8'h80, 8'h00, 8'h5A, 1'b0};
    vecs[5] = '{0, 1'b0, 8'h00, 8'h00, 8'h19, 1'b0};
    vecs[6] = '{1, 1'b0, 8'hFE, 8'h00, 8'hE7, 1'b0};
    vecs[7] = '{0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[8] = '{0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};

`ifdef MAU_READBACK_EN
    rb_rdata = 8'h00;
    rb_err   = 1'b1;
`else
    rb_rdata = 8'h3C;
    rb_err   = 1'b0;
`endif

    rst        = 1'b1;
    mem_clr    = 1'b1;
    req_valid  = '0;
    req_write  = '0;
    req_addr   = '0;
    req_wdata  = '0;
    force_zero = '0;

    // Reset: all outputs low while held, ready one cycle after release
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("rst_ctrl", 32'({req_ready[s], resp_valid[s], resp_err[s], busy[s], mem_enable[s], mem_write[s]}), 32'd0);
      check("rst_bus", 32'({read_addr[s], write_addr[s], write_data[s], resp_rdata[s]}), 32'd0);
    end
    rst     = 1'b0;
    mem_clr = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) check("ready_after_rst", 32'(req_ready[s]), 32'd1);

    // Single transactions: data, latency, strobe durations
    for (int i = 0; i < 9; i++) begin
      en0 = en_cnt[vecs[i].sel];
      we0 = we_cnt[vecs[i].sel];
      do_req(vecs[i].sel, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_rdata, vecs[i].exp_err, 1'b1, acc);
      wait_resp();
      check("en_cycles", 32'(en_cnt[vecs[i].sel] - en0), 32'(1 + vecs[i].sel));
      check("we_cycles", 32'(we_cnt[vecs[i].sel] - we0), 32'(vecs[i].wr));
    end

    // Back-to-back store then load, WAIT_CYCLES=0: spacing 3
    do_req(0, 1'b1, 8'h77, 8'hC3, 8'hC3, 1'b0, 1'b1, acc);
    do_req(0, 1'b0, 8'h77, 8'h00, 8'hC3, 1'b0, 1'b1, acc2);
    check("spacing_w0", 32'(acc2 - acc), 32'd3);
    wait_resp();
    wait_resp();

    // Request held through an in-flight load, WAIT_CYCLES=1: spacing 4
    do_req(1, 1'b0, 8'h31, 8'h00, 8'h28, 1'b0, 1'b1, acc);
    do_req(1, 1'b0, 8'h32, 8'h00, 8'h2B, 1'b0, 1'b1, acc2);
    check("spacing_w1", 32'(acc2 - acc), 32'd4);
    wait_resp();
    wait_resp();

    // Store whose readback is forced to zero
    force_zero[0] = 1'b1;
    do_req(0, 1'b1, 8'h40, 8'h3C, rb_rdata, rb_err, 1'b1, acc);
    wait_resp();
    force_zero[0] = 1'b0;

    // Reset during WAIT: strobe drops asynchronously, no response
    do_req(1, 1'b0, 8'h50, 8'h00, 8'h00, 1'b0, 1'b0, acc);
    @(negedge clk);
    check("mid_en_wait", 32'(mem_enable[1]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_en_async", 32'(mem_enable[1]), 32'd0);
    check("mid_busy_async", 32'(busy[1]), 32'd0);
    check("mid_rdata_rst", 32'(resp_rdata[1]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_no_resp", 32'(obs_n[1]), 32'(rd_idx[1]));
    check("mid_ready", 32'(req_ready[1]), 32'd1);
    do_req(1, 1'b0, 8'h22, 8'h00, 8'h3B, 1'b0, 1'b1, acc);
    wait_resp();

    repeat (4) @(negedge clk);
    for (int s = 0; s < 2; s++) check("no_stray_resp", 32'(obs_n[s]), 32'(rd_idx[s]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
